alu_arbiter: RTL and testbench

- Shares the single combinational Alu between two requesters, e.g. the core execute stage (requester 0) and the CSR/debug unit (requester 1).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Each response channel has a one-entry response buffer.
- The block arbitrates between requesters, drives the Alu combinationally from the winning request, and registers the result and zero flag per requester.

---
 rtl/alu_arbiter.sv | 115 +++++++++++
 tb/tb_alu_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Shares one combinational Alu between two valid/ready requesters and buffers
// one registered result per requester (round-robin or fixed priority).
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [3:0]            req0_op_i,
  input  logic [DATA_WIDTH-1:0] req0_rs1_i,
  input  logic [DATA_WIDTH-1:0] req0_rs2_i,
  output logic                  rsp0_valid_o,
  input  logic                  rsp0_ready_i,
  output logic [DATA_WIDTH-1:0] rsp0_rd_o,
  output logic                  rsp0_zr_o,

  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [3:0]            req1_op_i,
  input  logic [DATA_WIDTH-1:0] req1_rs1_i,
  input  logic [DATA_WIDTH-1:0] req1_rs2_i,
  output logic                  rsp1_valid_o,
  input  logic                  rsp1_ready_i,
  output logic [DATA_WIDTH-1:0] rsp1_rd_o,
  output logic                  rsp1_zr_o,

  output logic [3:0]            alu_op_o,
  output logic [DATA_WIDTH-1:0] alu_rs1_o,
  output logic [DATA_WIDTH-1:0] alu_rs2_o,
  input  logic [DATA_WIDTH-1:0] alu_rd_i,
  input  logic                  alu_zr_i
);

  logic last_grant;
  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;

  // A full buffer still accepts if it is being drained in the same cycle.
  assign elig0 = req0_valid_i && (!rsp0_valid_o || rsp0_ready_i);
  assign elig1 = req1_valid_i && (!rsp1_valid_o || rsp1_ready_i);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value to be remembered and no latch is inferred.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        if (FIXED_PRIO || last_grant) grant0 = 1'b1;
        else                          grant1 = 1'b1;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  always_comb begin
    alu_op_o  = 4'b0000;
    alu_rs1_o = '0;
    alu_rs2_o = '0;
    if (grant0) begin
      alu_op_o  = req0_op_i;
      alu_rs1_o = req0_rs1_i;
      alu_rs2_o = req0_rs2_i;
    end else if (grant1) begin
      alu_op_o  = req1_op_i;
      alu_rs1_o = req1_rs1_i;
      alu_rs2_o = req1_rs2_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= 1'b1;
      rsp0_valid_o <= 1'b0;
      rsp0_rd_o    <= '0;
      rsp0_zr_o    <= 1'b0;
      rsp1_valid_o <= 1'b0;
      rsp1_rd_o    <= '0;
      rsp1_zr_o    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (grant0) begin
        rsp0_valid_o <= 1'b1;
        rsp0_rd_o    <= alu_rd_i;
        rsp0_zr_o    <= alu_zr_i;
      end else if (rsp0_ready_i) begin
        rsp0_valid_o <= 1'b0;
      end

      if (grant1) begin
        rsp1_valid_o <= 1'b1;
        rsp1_rd_o    <= alu_rd_i;
        rsp1_zr_o    <= alu_zr_i;
      end else if (rsp1_ready_i) begin
        rsp1_valid_o <= 1'b0;
      end

      // Idle cycles leave the round-robin pointer where it was.
      if (grant0)      last_grant <= 1'b0;
      else if (grant1) last_grant <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter; a behavioural Alu stand-in
// closes the loop and a transaction-level model checks the random run.
module tb_alu_arbiter;

  localparam logic [3:0] OP_SUM = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v0, v1, rr0, rr1;
  logic [3:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;

  logic        rdy0, rdy1, rsp_v0, rsp_v1, rsp_zr0, rsp_zr1;
  logic [31:0] rsp_rd0, rsp_rd1;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_rd;
  logic        alu_zr;

  logic        f_rdy0, f_rdy1, f_rsp_v0, f_rsp_v1, f_rsp_zr0, f_rsp_zr1;
  logic [31:0] f_rsp_rd0, f_rsp_rd1;
  logic [3:0]  f_alu_op;
  logic [31:0] f_alu_a, f_alu_b, f_alu_rd;
  logic        f_alu_zr;

  int total = 0;
  int bad   = 0;

  // Behavioural Alu; anything outside the known opcodes returns rs1.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_SUM:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a;
    endcase
  endfunction

  assign alu_rd   = alu_f(alu_op, alu_a, alu_b);
  assign alu_zr   = (alu_rd == 32'd0);
  assign f_alu_rd = alu_f(f_alu_op, f_alu_a, f_alu_b);
  assign f_alu_zr = (f_alu_rd == 32'd0);

  alu_arbiter #(.DATA_WIDTH(32), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_op_i(op0), .req0_rs1_i(a0), .req0_rs2_i(b0),
    .rsp0_valid_o(rsp_v0), .rsp0_ready_i(rr0), .rsp0_rd_o(rsp_rd0), .rsp0_zr_o(rsp_zr0),
    .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_op_i(op1), .req1_rs1_i(a1), .req1_rs2_i(b1),
    .rsp1_valid_o(rsp_v1), .rsp1_ready_i(rr1), .rsp1_rd_o(rsp_rd1), .rsp1_zr_o(rsp_zr1),
    .alu_op_o(alu_op), .alu_rs1_o(alu_a), .alu_rs2_o(alu_b), .alu_rd_i(alu_rd), .alu_zr_i(alu_zr)
  );

  alu_arbiter #(.DATA_WIDTH(32), .FIXED_PRIO(1'b1)) dut_fixed (
    .clk(clk), .rst(rst),
    .req0_valid_i(v0), .req0_ready_o(f_rdy0), .req0_op_i(op0), .req0_rs1_i(a0), .req0_rs2_i(b0),
    .rsp0_valid_o(f_rsp_v0), .rsp0_ready_i(rr0), .rsp0_rd_o(f_rsp_rd0), .rsp0_zr_o(f_rsp_zr0),
    .req1_valid_i(v1), .req1_ready_o(f_rdy1), .req1_op_i(op1), .req1_rs1_i(a1), .req1_rs2_i(b1),
    .rsp1_valid_o(f_rsp_v1), .rsp1_ready_i(rr1), .rsp1_rd_o(f_rsp_rd1), .rsp1_zr_o(f_rsp_zr1),
    .alu_op_o(f_alu_op), .alu_rs1_o(f_alu_a), .alu_rs2_o(f_alu_b), .alu_rd_i(f_alu_rd), .alu_zr_i(f_alu_zr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    v0 = 1'b0; op0 = 4'd0; a0 = 32'd0; b0 = 32'd0; rr0 = 1'b1;
    v1 = 1'b0; op1 = 4'd0; a1 = 32'd0; b1 = 32'd0; rr1 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    v0 = 1'b1; op0 = OP_SUM; a0 = 32'd1; b0 = 32'd1;
    #2;
    total++; if (rdy0 !== 1'b0)    begin bad++; $display("FAIL reset_rdy0: got %b want 0", rdy0); end
    total++; if (rsp_v0 !== 1'b0)  begin bad++; $display("FAIL reset_rsp_v0: got %b want 0", rsp_v0); end
    total++; if (rsp_v1 !== 1'b0)  begin bad++; $display("FAIL reset_rsp_v1: got %b want 0", rsp_v1); end
    total++; if (rsp_rd0 !== 32'd0) begin bad++; $display("FAIL reset_rd0: got %0h want 0", rsp_rd0); end
    total++; if (rsp_zr1 !== 1'b0) begin bad++; $display("FAIL reset_zr1: got %b want 0", rsp_zr1); end
    tick();
    total++; if (rsp_v0 !== 1'b0)  begin bad++; $display("FAIL reset_hold_rsp_v0: got %b want 0", rsp_v0); end
    v0 = 1'b0;
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    idle_inputs();
    v0 = 1'b1; op0 = OP_SUB; a0 = 32'd9;    b0 = 32'd9;
    v1 = 1'b1; op1 = OP_OR;  a1 = 32'hF0;   b1 = 32'h0F;
    for (int i = 0; i < 4; i++) begin
      logic win0;
      win0 = (i % 2 == 0);
      #1;
      total++; if (rdy0 !== win0 || rdy1 !== !win0) begin bad++; $display("FAIL contention_grant[%0d]: got rdy0=%b rdy1=%b want rdy0=%b", i, rdy0, rdy1, win0); end
      total++; if (alu_op !== (win0 ? OP_SUB : OP_OR)) begin bad++; $display("FAIL contention_alu_op[%0d]: got %0h", i, alu_op); end
      tick();
      if (win0) begin
        total++; if (rsp_v0 !== 1'b1 || rsp_rd0 !== 32'd0 || rsp_zr0 !== 1'b1) begin bad++; $display("FAIL contention_rsp0[%0d]: got v=%b rd=%0h zr=%b want 1/0/1", i, rsp_v0, rsp_rd0, rsp_zr0); end
      end else begin
        total++; if (rsp_v1 !== 1'b1 || rsp_rd1 !== 32'hFF || rsp_zr1 !== 1'b0) begin bad++; $display("FAIL contention_rsp1[%0d]: got v=%b rd=%0h zr=%b want 1/ff/0", i, rsp_v1, rsp_rd1, rsp_zr1); end
      end
    end
    v0 = 1'b0; v1 = 1'b0;
    tick();
    total++; if (rsp_v0 !== 1'b0 || rsp_v1 !== 1'b0) begin bad++; $display("FAIL contention_drain: got v0=%b v1=%b want 0/0", rsp_v0, rsp_v1); end
  endtask

  task automatic test_single();
    idle_inputs();
    v0 = 1'b1; op0 = OP_SUM; a0 = 32'd5; b0 = 32'd7;
    #1;
    total++; if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin bad++; $display("FAIL single_ready: got rdy0=%b rdy1=%b want 1/0", rdy0, rdy1); end
    total++; if (alu_op !== OP_SUM || alu_a !== 32'd5 || alu_b !== 32'd7) begin bad++; $display("FAIL single_alu_drive: got op=%0h a=%0h b=%0h", alu_op, alu_a, alu_b); end
    tick();
    v0 = 1'b0;
    total++; if (rsp_v0 !== 1'b1 || rsp_rd0 !== 32'd12 || rsp_zr0 !== 1'b0) begin bad++; $display("FAIL single_rsp0: got v=%b rd=%0d zr=%b want 1/12/0", rsp_v0, rsp_rd0, rsp_zr0); end
    total++; if (rsp_v1 !== 1'b0) begin bad++; $display("FAIL single_rsp1_quiet: got %b want 0", rsp_v1); end
    #1;
    total++; if (alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin bad++; $display("FAIL idle_alu_drive: got op=%0h a=%0h b=%0h want zeros", alu_op, alu_a, alu_b); end
    tick();
    total++; if (rsp_v0 !== 1'b0 || rsp_rd0 !== 32'd12) begin bad++; $display("FAIL single_drain_hold: got v=%b rd=%0d want 0/12", rsp_v0, rsp_rd0); end
  endtask

  task automatic test_back_pressure();
    idle_inputs();
    rr0 = 1'b0;
    v0 = 1'b1; op0 = OP_SUM; a0 = 32'd1; b0 = 32'd2;
    #1;
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL bp_first_grant: got %b want 1", rdy0); end
    tick();
    total++; if (rsp_v0 !== 1'b1 || rsp_rd0 !== 32'd3) begin bad++; $display("FAIL bp_first_rsp: got v=%b rd=%0d want 1/3", rsp_v0, rsp_rd0); end
    op0 = OP_SUB; a0 = 32'd10; b0 = 32'd3;
    v1 = 1'b1; op1 = OP_AND; a1 = 32'hFF; b1 = 32'h0F;
    #1;
    total++; if (rdy0 !== 1'b0 || rdy1 !== 1'b1) begin bad++; $display("FAIL bp_grant_other: got rdy0=%b rdy1=%b want 0/1", rdy0, rdy1); end
    total++; if (alu_op !== OP_AND) begin bad++; $display("FAIL bp_alu_op: got %0h want %0h", alu_op, OP_AND); end
    tick();
    total++; if (rsp_v1 !== 1'b1 || rsp_rd1 !== 32'h0F) begin bad++; $display("FAIL bp_rsp1: got v=%b rd=%0h want 1/f", rsp_v1, rsp_rd1); end
    total++; if (rsp_v0 !== 1'b1 || rsp_rd0 !== 32'd3) begin bad++; $display("FAIL bp_rsp0_held: got v=%b rd=%0d want 1/3", rsp_v0, rsp_rd0); end
    v1 = 1'b0;
    #1;
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL bp_still_blocked: got %b want 0", rdy0); end
    tick();
    rr0 = 1'b1;
    #1;
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL bp_grant_on_drain: got %b want 1", rdy0); end
    tick();
    total++; if (rsp_v0 !== 1'b1 || rsp_rd0 !== 32'd7) begin bad++; $display("FAIL bp_reload: got v=%b rd=%0d want 1/7", rsp_v0, rsp_rd0); end
    v0 = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    v0 = 1'b1; op0 = OP_SLL; a0 = 32'd1;
    for (int k = 0; k < 8; k++) begin
      b0 = k;
      #1;
      total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, rdy0); end
      tick();
      total++; if (rsp_v0 !== 1'b1 || rsp_rd0 !== (32'd1 << k)) begin bad++; $display("FAIL b2b_rsp[%0d]: got v=%b rd=%0d want 1/%0d", k, rsp_v0, rsp_rd0, 32'd1 << k); end
    end
    v0 = 1'b0;
    tick();
  endtask

  task automatic test_fixed_prio();
    idle_inputs();
    v0 = 1'b1; op0 = OP_SUM; a0 = 32'd2; b0 = 32'd3;
    v1 = 1'b1; op1 = OP_XOR; a1 = 32'd6; b1 = 32'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (f_rdy0 !== 1'b1 || f_rdy1 !== 1'b0) begin bad++; $display("FAIL fixed_grant[%0d]: got rdy0=%b rdy1=%b want 1/0", i, f_rdy0, f_rdy1); end
      tick();
    end
    v0 = 1'b0;
    #1;
    total++; if (f_rdy1 !== 1'b1) begin bad++; $display("FAIL fixed_r1_when_r0_idle: got %b want 1", f_rdy1); end
    tick();
    total++; if (f_rsp_v1 !== 1'b1 || f_rsp_rd1 !== 32'd5) begin bad++; $display("FAIL fixed_rsp1: got v=%b rd=%0d want 1/5", f_rsp_v1, f_rsp_rd1); end
    v1 = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    rr1 = 1'b0;
    v1 = 1'b1; op1 = OP_SUB; a1 = 32'd8; b1 = 32'd1;
    #1;
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL areset_setup_grant: got %b want 1", rdy1); end
    tick();
    total++; if (rsp_v1 !== 1'b1 || rsp_rd1 !== 32'd7) begin bad++; $display("FAIL areset_setup_rsp: got v=%b rd=%0d want 1/7", rsp_v1, rsp_rd1); end
    v1 = 1'b0;
    #1 rst = 1'b1;
    #1;
    total++; if (rsp_v1 !== 1'b0 || rsp_rd1 !== 32'd0) begin bad++; $display("FAIL areset_immediate: got v=%b rd=%0h want 0/0", rsp_v1, rsp_rd1); end
    rr0 = 1'b1; rr1 = 1'b1;
    v0 = 1'b1; op0 = OP_OR; a0 = 32'h3; b0 = 32'h4;
    v1 = 1'b1; op1 = OP_OR; a1 = 32'h1; b1 = 32'h8;
    #1;
    total++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin bad++; $display("FAIL areset_ready_low: got rdy0=%b rdy1=%b want 0/0", rdy0, rdy1); end
    #1 rst = 1'b0;
    #1;
    total++; if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin bad++; $display("FAIL areset_first_contest: got rdy0=%b rdy1=%b want 1/0", rdy0, rdy1); end
    tick();
    total++; if (rsp_v0 !== 1'b1 || rsp_rd0 !== 32'h7) begin bad++; $display("FAIL areset_first_rsp: got v=%b rd=%0h want 1/7", rsp_v0, rsp_rd0); end
    v0 = 1'b0; v1 = 1'b0;
    tick();
  endtask

  // Transaction-level reference: each buffer is a one-slot mailbox, the
  // arbiter picks per the eligibility rules, results come from alu_f.
  task automatic test_random();
    logic        m_full[2];
    logic [31:0] m_rd[2];
    logic        m_zr[2];
    int          m_last;
    logic        rv[2], rrd[2], pend[2], elig[2], win[2];
    logic [3:0]  rop[2];
    logic [31:0] ra[2], rb[2];
    logic [31:0] res;

    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    m_last = 1;
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 1'b0; m_rd[k] = 32'd0; m_zr[k] = 1'b0; pend[k] = 1'b0;
      rv[k] = 1'b0; rop[k] = 4'd0; ra[k] = 32'd0; rb[k] = 32'd0;
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k]) begin
          rv[k]  = ($urandom_range(0, 3) != 0);
          rop[k] = 4'($urandom_range(0, 9));
          ra[k]  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
          rb[k]  = ($urandom_range(0, 3) == 0) ? ra[k] : $urandom;
        end
        rrd[k] = ($urandom_range(0, 3) != 0);
      end
      v0 = rv[0]; op0 = rop[0]; a0 = ra[0]; b0 = rb[0]; rr0 = rrd[0];
      v1 = rv[1]; op1 = rop[1]; a1 = ra[1]; b1 = rb[1]; rr1 = rrd[1];

      for (int k = 0; k < 2; k++) begin
        elig[k] = rv[k] && (!m_full[k] || rrd[k]);
        win[k]  = 1'b0;
      end
      if (elig[0] && elig[1]) win[(m_last == 0) ? 1 : 0] = 1'b1;
      else begin win[0] = elig[0]; win[1] = elig[1]; end

      #1;
      total++; if (rdy0 !== win[0] || rdy1 !== win[1]) begin bad++; $display("FAIL rand_grant[%0d]: got rdy0=%b rdy1=%b want %b/%b", cyc, rdy0, rdy1, win[0], win[1]); end
      total++;
      if (win[0] && (alu_op !== rop[0] || alu_a !== ra[0] || alu_b !== rb[0])) begin bad++; $display("FAIL rand_alu_drive0[%0d]: got op=%0h a=%0h", cyc, alu_op, alu_a); end
      else if (win[1] && (alu_op !== rop[1] || alu_a !== ra[1] || alu_b !== rb[1])) begin bad++; $display("FAIL rand_alu_drive1[%0d]: got op=%0h a=%0h", cyc, alu_op, alu_a); end
      else if (!win[0] && !win[1] && (alu_op !== 4'd0 || alu_a !== 32'd0)) begin bad++; $display("FAIL rand_alu_idle[%0d]: got op=%0h a=%0h", cyc, alu_op, alu_a); end

      for (int k = 0; k < 2; k++) pend[k] = rv[k] && !win[k];
      tick();

      for (int k = 0; k < 2; k++) begin
        if (win[k]) begin
          res = alu_f(rop[k], ra[k], rb[k]);
          m_full[k] = 1'b1; m_rd[k] = res; m_zr[k] = (res == 32'd0);
          m_last = k;
        end else if (rrd[k]) begin
          m_full[k] = 1'b0;
        end
      end
      total++; if (rsp_v0 !== m_full[0] || rsp_rd0 !== m_rd[0] || rsp_zr0 !== m_zr[0]) begin bad++; $display("FAIL rand_rsp0[%0d]: got v=%b rd=%0h zr=%b want %b/%0h/%b", cyc, rsp_v0, rsp_rd0, rsp_zr0, m_full[0], m_rd[0], m_zr[0]); end
      total++; if (rsp_v1 !== m_full[1] || rsp_rd1 !== m_rd[1] || rsp_zr1 !== m_zr[1]) begin bad++; $display("FAIL rand_rsp1[%0d]: got v=%b rd=%0h zr=%b want %b/%0h/%b", cyc, rsp_v1, rsp_rd1, rsp_zr1, m_full[1], m_rd[1], m_zr[1]); end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_contention();
    test_single();
    test_back_pressure();
    test_back_to_back();
    test_fixed_prio();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
